// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth signed multiplier: one multiplier bit per EVAL/SHIFT pair,
// start/busy/done handshake, registered product held until the next completion.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             multiplicand,
  input  logic [WIDTH-1:0]             multiplier,
  output logic                         busy,
  output logic                         done,
  output logic [2*WIDTH-1:0]           product,
  output logic                         op_add,
  output logic                         op_sub,
  output logic [$clog2(WIDTH+1)-1:0]   iter
);

  localparam int IW = $clog2(WIDTH+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 op_add_q, op_add_d;
  logic                 op_sub_q, op_sub_d;

  // Next-state, datapath and (pre-registered) output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    iter_d    = iter_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        a_d     = '0;
        m_d     = {multiplicand[WIDTH-1], multiplicand};
        q_d     = multiplier;
        qm1_d   = 1'b0;
        iter_d  = IW'(WIDTH);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        case ({q_q[0], qm1_q})
          2'b01:   a_d = a_q + m_q;
          2'b10:   a_d = a_q - m_q;
          default: a_d = a_q;
        endcase
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
        iter_d = iter_q - IW'(1);
        // Product is taken from the post-shift value so it is valid while done is high
        if (iter_q == IW'(1)) begin
          state_d   = S_DONE;
          product_d = {a_q, q_q[WIDTH-1:1]};
        end else begin
          state_d   = S_EVAL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    op_add_d = (state_d == S_EVAL) && ({q_d[0], qm1_d} == 2'b01);
    op_sub_d = (state_d == S_EVAL) && ({q_d[0], qm1_d} == 2'b10);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      iter_q    <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_add_q  <= 1'b0;
      op_sub_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_add_q  <= op_add_d;
      op_sub_q  <= op_sub_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign op_add  = op_add_q;
  assign op_sub  = op_sub_q;
  assign iter    = iter_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed corners plus random operands against
// an arithmetic product model and a Booth-recoding model of the op_add/op_sub sequence.
module tb_booth_seq_ctrl;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int IW = $clog2(W + 1);
  localparam int LAT = 2 * W + 2;

  logic            CLOCK_50;
  logic            reset_n;
  logic            start;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic            busy;
  logic            done;
  logic [PW-1:0]   product;
  logic            op_add;
  logic            op_sub;
  logic [IW-1:0]   iter;

  int n_checks;
  int n_errors;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .op_add       (op_add),
    .op_sub       (op_sub),
    .iter         (iter)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [PW-1:0] model_product(input logic [W-1:0] m, input logic [W-1:0] q);
    int mi;
    int qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    return PW'(mi * qi);
  endfunction

  // Run one multiply; poke>0 re-asserts start with other operands at that cycle of the op
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int poke);
    logic [PW-1:0] exp_p;
    logic [63:0]   add_exp, sub_exp, add_obs, sub_obs;
    logic [W:0]    qx;
    int            cyc;
    exp_p   = model_product(m, q);
    add_exp = '0;
    sub_exp = '0;
    qx      = {q, 1'b0};
    for (int i = 0; i < W; i++) begin
      if (qx[i+1 -: 2] == 2'b01) add_exp[2 + 2*i] = 1'b1;
      if (qx[i+1 -: 2] == 2'b10) sub_exp[2 + 2*i] = 1'b1;
    end
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_rise", 64'(busy), 64'd1);
    cyc     = 1;
    add_obs = '0;
    sub_obs = '0;
    while (cyc < 40) begin
      add_obs[cyc] = op_add;
      sub_obs[cyc] = op_sub;
      if (cyc == 2) begin
        check_eq("iter_first_eval", 64'(iter), 64'(W));
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
      end
      if (poke > 0 && cyc == poke) begin
        start        = 1'b1;
        multiplicand = ~m;
        multiplier   = q + W'(1);
      end else begin
        start = 1'b0;
      end
      if (done) break;
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq("latency", 64'(cyc), 64'(LAT));
    check_eq("product", 64'(product), 64'(exp_p));
    check_eq("op_add_seq", add_obs, add_exp);
    check_eq("op_sub_seq", sub_obs, sub_exp);
    check_eq("iter_at_done", 64'(iter), 64'd0);
    tick();
    check_eq("done_single", 64'(done), 64'd0);
    check_eq("idle_after", 64'(busy), 64'd0);
    check_eq("product_held", 64'(product), 64'(exp_p));
    tick();
    check_eq("not_queued", 64'(busy), 64'd0);
  endtask

  initial begin
    int dcount;
    int last;
    n_checks     = 0;
    n_errors     = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_product", 64'(product), 64'd0);
    check_eq("rst_ops", 64'({op_add, op_sub}), 64'd0);
    check_eq("rst_iter", 64'(iter), 64'd0);
    reset_n = 1'b1;
    tick();

    run_op(8'd3, 8'd5, 0);
    run_op(8'hFD, 8'd7, 0);
    run_op(8'h7F, 8'h80, 0);
    run_op(8'h80, 8'h80, 0);
    run_op(8'h00, 8'h55, 0);
    run_op(8'h15, 8'hE9, 5);

    // Reset in the middle of an operation (cycle 5 of the op is a SHIFT)
    multiplicand = 8'd9;
    multiplier   = 8'd11;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_product", 64'(product), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    dcount = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (done) dcount++;
    end
    check_eq("midrst_no_done", 64'(dcount), 64'd0);
    run_op(8'd9, 8'd11, 0);

    // start held high: back-to-back operations
    multiplicand = 8'd2;
    multiplier   = 8'hFC;
    start        = 1'b1;
    dcount       = 0;
    last         = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (done) begin
        dcount++;
        check_eq("hold_product", 64'(product), 64'hFFF8);
        if (last > 0) check_eq("hold_period", 64'(t - last), 64'(LAT + 1));
        else          check_eq("hold_first", 64'(t), 64'(LAT));
        last = t;
      end
    end
    check_eq("hold_count", 64'(dcount), 64'd3);
    start = 1'b0;
    repeat (25) tick();
    check_eq("hold_idle", 64'(busy), 64'd0);

    for (int r = 0; r < 20; r++) begin
      run_op(W'($urandom), W'($urandom), (r % 4 == 0) ? int'($urandom_range(3, 15)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
